sr_ff_sequencer: RTL

SR_FF_SEQUENCER -- requirements
Module: sr_ff_sequencer

---
 rtl/sr_ff_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sr_ff_sequencer.sv
// Round-robin sequencer that serialises set/reset requests onto one external
// master-slave SR flip-flop and checks its readback after every operation.
module sr_ff_sequencer #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic            C,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] OP,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] DONE,
    output logic            S,
    output logic            R,
    input  logic            Q,
    input  logic            QBAR,
    output logic            BUSY,
    output logic            ERR
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_drive  = 2'd1;
    localparam logic [1:0] st_settle = 2'd2;
    localparam logic [1:0] st_check  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            op_q, op_d;
    logic [IW-1:0]   last_q, last_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   win_idx;
    logic            win_ok;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int unsigned k;
        k       = 0;
        win_idx = '0;
        win_ok  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(last_q) + 32'd1 + i) % NREQ;
            if (!win_ok && REQ[IW'(k)]) begin
                win_ok  = 1'b1;
                win_idx = IW'(k);
            end
        end
    end

    // Next-state and registered-output logic; S and R default low so they
    // are only ever driven as a complementary pair inside DRIVE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        op_d    = op_q;
        last_d  = last_q;
        err_d   = err_q;

        case (state_q)
            st_idle: begin
                if (win_ok) begin
                    state_d = st_drive;
                    gnt_d   = NREQ'(1'b1) << win_idx;
                    op_d    = OP[win_idx];
                    last_d  = win_idx;
                    s_d     = OP[win_idx];
                    r_d     = ~OP[win_idx];
                    cnt_d   = CW'(HOLD_CYC - 1);
                end
            end
            st_drive: begin
                if (cnt_q == '0) begin
                    state_d = st_settle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    s_d   = op_q;
                    r_d   = ~op_q;
                end
            end
            st_settle: begin
                state_d = st_check;
                done_d  = gnt_q;
            end
            st_check: begin
                state_d = st_idle;
                gnt_d   = '0;
                if ((Q != op_q) || (QBAR == Q)) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = st_idle;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != st_idle);
    end

    // State register; reset wins over any in-flight operation.
    always_ff @(posedge C) begin
        if (RST) begin
            state_q <= st_idle;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            op_q    <= 1'b0;
            last_q  <= IW'(NREQ - 1);
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            s_q     <= s_d;
            r_q     <= r_d;
            op_q    <= op_d;
            last_q  <= last_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign S    = s_q;
    assign R    = r_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

endmodule
